cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the execution units: integer, multiply, divide and the memory issue unit.
- Each unit hands over a finished result through a valid/ready handshake into a one-entry holding register.
- A round-robin arbiter publishes one result per cycle onto a registered CDB, which feeds the reservation stations, ROB and register status table.
- The arbiter applies backpressure, so a unit with a fixed-latency pipeline must stall its pipe while its ready signal is low.

Parameters:
- N_UNITS, 4, number of requesting execution units. Index 0 = int, 1 = mult, 2 = div, 3 = mem.
- TAG_W, 6, width of the ROB/physical tag.
- DATA_W, 32, width of the result.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  mispredict flush; discards every pending result.
- req_valid  input  N_UNITS  per-unit result valid.
- req_tag  input  N_UNITS*TAG_W  per-unit destination tag; unit i occupies slice [i*TAG_W +: TAG_W].
- req_result  input  N_UNITS*DATA_W  per-unit result data, sliced the same way as req_tag.
- req_branch  input  N_UNITS  per-unit "result is a branch" flag.
- req_taken  input  N_UNITS  per-unit branch-taken flag.
- req_ready  output  N_UNITS  holding register of unit i can accept this cycle.
- cdb_valid  output  1  CDB broadcast valid.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_result  output  DATA_W  broadcast data.
- cdb_branch  output  1  broadcast branch flag.
- cdb_taken  output  1  broadcast branch-taken flag.
- cdb_src  output  $clog2(N_UNITS)  index of the unit that owns the current broadcast.

Behaviour:
- Reset (rst=1 at an edge):
  - all holding registers become empty;
  - the round-robin pointer becomes 0;
  - cdb_valid=0, cdb_tag=0, cdb_result=0, cdb_branch=0, cdb_taken=0, cdb_src=0.
  - req_ready is forced to 0 while rst=1.
- Holding register per unit: occ[i] plus tag, result, branch and taken fields.
- req_ready[i] = ~rst & ~flush & (~occ[i] | grant[i]). This is combinational, so a unit that is granted can refill its register in the same cycle.
- Accept: when req_valid[i] & req_ready[i] at an edge, the register loads and occ[i]=1.
- If a register is granted and not refilled in the same cycle, it clears: occ[i]=0.
- Arbitration is combinational over occ[]:
  - scan starts at the pointer and proceeds pointer, pointer+1, ..., wrapping modulo N_UNITS;
  - the first occupied index is granted; at most one grant per cycle.
- Pointer update: after a grant to unit g, pointer = (g+1) mod N_UNITS. With no grant, the pointer holds.
- CDB output registers:
  - on a grant, they load the granted register's fields, cdb_valid=1, cdb_src=g;
  - with no grant, cdb_valid=0 and the other CDB fields hold their previous values.
- Latency:
  - a request accepted at edge E0 is visible on the CDB after edge E1 at the earliest (one cycle in the holding register);
  - worst case is after edge E0+N_UNITS, because every occupied register is granted within N_UNITS cycles (no starvation).
- Throughput: one broadcast per cycle sustained when at least one register is occupied.
- Flush (at an edge):
  - all occ are cleared and cdb_valid=0 next cycle;
  - nothing is accepted that cycle;
  - the pointer holds.
  - Flush takes priority over accept and grant. rst takes priority over flush.
- Requests with req_valid=0, for example stores from the mem unit, are never accepted.
- Simultaneous requests from all units: they are granted in pointer order, one per cycle; the others stay held and keep their req_ready low.
- Assertions:
  - never more than one grant per cycle;
  - no holding register is overwritten while occupied and not granted;
  - cdb_valid implies that cdb_src was occupied in the previous cycle.

Decomposition:
- Shared package (utils):
  - the cdb_bfm struct, reused as the holding-register and CDB record;
  - the unit index constants UNIT_INT=0, UNIT_MULT=1, UNIT_DIV=2, UNIT_MEM=3.
- One sub-module, rr_arbiter:
  - inputs: N-bit request, pointer;
  - outputs: one-hot grant, encoded index, any_grant;
  - combinational, parameterized by N.
- The holding registers and CDB registers use ffd_param instances, with enables driven by the accept and grant logic.

Test Plan:
1. Reset then idle:
   - Stimulus: rst=1 for 2 cycles, then release.
   - Required: cdb_valid=0; req_ready=4'b0000 during rst and 4'b1111 after release.
2. Single request:
   - Stimulus: unit 3 sends tag=5, result=0xDEADBEEF at edge E0.
   - Required: after E1, cdb_valid=1, cdb_tag=5, cdb_result=0xDEADBEEF, cdb_src=3; next cycle cdb_valid=0.
3. All units request simultaneously with tags 1, 2, 3, 4 and the pointer at 0:
   - Required: broadcasts in order tag 1, 2, 3, 4 on four consecutive cycles.
   - Then a fresh request from unit 0 is granted ahead of the others only after the pointer wraps.
4. Back-to-back from one unit: unit 1 holds req_valid=1 continuously with tags 7, 8, 9.
   - Required: req_ready[1] stays 1 through its grant cycles; tags 7, 8, 9 appear on consecutive cycles with cdb_src=1.
5. Flush:
   - Stimulus: units 0 and 2 are occupied (tags 10, 11) and flush=1 for one cycle.
   - Required: neither tag is ever broadcast; cdb_valid=0 the following cycle; req_ready=0 during the flush cycle.
6. Fairness and branch flags:
   - Stimulus: unit 0 requests continuously while unit 2 sends one branch (branch=1, taken=1, tag=12).
   - Required: tag 12 is broadcast within 4 cycles of its acceptance, with cdb_branch=1 and cdb_taken=1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: the per-unit result record and unit indices.
// The record doubles as the holding-register and broadcast-register payload.
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    localparam int UNIT_INT  = 0;
    localparam int UNIT_MULT = 1;
    localparam int UNIT_DIV  = 2;
    localparam int UNIT_MEM  = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] result;
        logic                  branch;
        logic                  taken;
    } cdb_bfm;

    // Round-robin successor of a unit index.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_ffd_param.sv
// Enable flop of configurable width with synchronous active-high reset.
module ffd_param #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_gnt
);

    localparam int IDX_W = $clog2(N);

    // First pass covers ptr..N-1, second pass the wrapped part 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (i >= int'(ptr))) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (i < int'(ptr))) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per execution unit,
// round-robin selection, and a registered broadcast toward RS/ROB/RAT.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [N_UNITS-1:0]           req_valid,
    input  logic [N_UNITS*TAG_W-1:0]     req_tag,
    input  logic [N_UNITS*DATA_W-1:0]    req_result,
    input  logic [N_UNITS-1:0]           req_branch,
    input  logic [N_UNITS-1:0]           req_taken,
    output logic [N_UNITS-1:0]           req_ready,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [DATA_W-1:0]            cdb_result,
    output logic                         cdb_branch,
    output logic                         cdb_taken,
    output logic [$clog2(N_UNITS)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(N_UNITS);
    localparam int REC_W = $bits(cdb_bfm);

    logic [N_UNITS-1:0] occ_d;
    logic [N_UNITS-1:0] occ_q;
    logic [N_UNITS-1:0] accept;
    logic [N_UNITS-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic               cdb_load;
    logic [SRC_W-1:0]   ptr_d;
    logic [SRC_W-1:0]   ptr_q;
    logic               cdb_valid_d;
    logic               cdb_valid_q;
    logic [SRC_W-1:0]   cdb_src_d;
    logic [SRC_W-1:0]   cdb_src_q;
    cdb_bfm             hold_d [N_UNITS];
    cdb_bfm             hold_q [N_UNITS];
    cdb_bfm             cdb_rec_d;
    cdb_bfm             cdb_rec_q;

    rr_arbiter #(
        .N(N_UNITS)
    ) u_rr (
        .req     (occ_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // A granted unit may refill in the same cycle; flush blocks both accept and grant.
    always_comb begin
        req_ready   = {N_UNITS{~rst & ~flush}} & (~occ_q | gnt);
        accept      = req_valid & req_ready;
        cdb_load    = any_gnt & ~flush;
        occ_d       = flush ? '0 : ((occ_q & ~gnt) | accept);
        for (int i = 0; i < N_UNITS; i++) begin
            hold_d[i].tag    = req_tag[i*TAG_W +: TAG_W];
            hold_d[i].result = req_result[i*DATA_W +: DATA_W];
            hold_d[i].branch = req_branch[i];
            hold_d[i].taken  = req_taken[i];
        end
        cdb_rec_d   = hold_q[gnt_idx];
        cdb_src_d   = gnt_idx;
        cdb_valid_d = cdb_load;
        ptr_d       = SRC_W'(next_ptr(32'(gnt_idx), N_UNITS));
    end

    for (genvar i = 0; i < N_UNITS; i++) begin : g_hold
        ffd_param #(
            .W(REC_W)
        ) u_hold (
            .clk (clk),
            .rst (rst),
            .en  (accept[i]),
            .d   (hold_d[i]),
            .q   (hold_q[i])
        );
    end

    ffd_param #(.W(N_UNITS)) u_occ (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (occ_d),
        .q   (occ_q)
    );

    ffd_param #(.W(SRC_W)) u_ptr (
        .clk (clk),
        .rst (rst),
        .en  (cdb_load),
        .d   (ptr_d),
        .q   (ptr_q)
    );

    ffd_param #(.W(1)) u_cdb_valid (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (cdb_valid_d),
        .q   (cdb_valid_q)
    );

    ffd_param #(.W(REC_W)) u_cdb_rec (
        .clk (clk),
        .rst (rst),
        .en  (cdb_load),
        .d   (cdb_rec_d),
        .q   (cdb_rec_q)
    );

    ffd_param #(.W(SRC_W)) u_cdb_src (
        .clk (clk),
        .rst (rst),
        .en  (cdb_load),
        .d   (cdb_src_d),
        .q   (cdb_src_q)
    );

    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_rec_q.tag;
    assign cdb_result = cdb_rec_q.result;
    assign cdb_branch = cdb_rec_q.branch;
    assign cdb_taken  = cdb_rec_q.taken;
    assign cdb_src    = cdb_src_q;

    a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
        (accept & occ_q & ~gnt) == '0);

    a_src_occupied: assert property (@(posedge clk) disable iff (rst)
        cdb_valid_q |-> (($past(gnt_idx) == cdb_src_q) && $past(occ_q[gnt_idx])));

endmodule
